eau_seq: RTL
============

# eau_seq

Parametrised effective-address unit for the load/store unit. Assembles an `ADDR_W`-bit address from `DATA_W`-bit bus beats, loaded LSB-first through an internal byte pointer into a shadow register. The full address commits atomically, so the previously committed address stays valid on `q` during a reload. Supports post-modify stepping (increment or decrement by a programmable stride) with a wrap flag, and gates its output with `oe`. Sits between the 8-bit data bus and the memory address path.

## Interface
Parameters:
- `DATA_W`, 8: width of one load beat.
- `ADDR_W`, 16: address width; must be an integer multiple of `DATA_W` (`NBEAT = ADDR_W/DATA_W`, with `NBEAT >= 1`).
- `STRIDE_W`, 4: width of the unsigned stride input.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `d`  in  `DATA_W`  load beat data.
- `ld`  in  1  write `d` into the shadow beat selected by the pointer, then advance the pointer.
- `step`  in  1  post-modify the committed address.
- `dir`  in  1  step direction: 0 = add, 1 = subtract.
- `stride`  in  `STRIDE_W`  unsigned step amount.
- `oe`  in  1  output enable.
- `q`  out  `ADDR_W`  committed address when `oe && valid`, else 0 (no tri-state).
- `valid`  out  1  a committed address exists.
- `busy`  out  1  a load sequence is in progress.
- `wrap`  out  1  one-cycle pulse when a step carried or borrowed out of `ADDR_W`.

## Operation
- Registers: `addr` (committed), `shadow` (`ADDR_W`), `ptr` (beat index, `clog2(NBEAT)` bits, minimum 1), `valid`, `wrap`, and a 2-state FSM.
- Reset (`rst==0` at an edge): `addr=0`, `shadow=0`, `ptr=0`, `valid=0`, `wrap=0`, FSM=IDLE. As a result `q=0` and `busy=0`. Reset overrides every other input, and any partial load is discarded.
- FSM states:
  - **IDLE.** `busy=0`. On `ld`: write beat 0. If `NBEAT==1`, commit in the same edge and stay in IDLE. Otherwise set `ptr=1` and go to LOAD.
  - **LOAD.** `busy=1`. On `ld`: write beat `ptr`. If `ptr==NBEAT-1`, commit: `addr = {d, shadow[lower beats]}`, set `valid=1`, `ptr=0`, return to IDLE. Otherwise `ptr++`. With no `ld`, the FSM holds indefinitely; there is no timeout.
- Commit writes the complete new address in a single edge; intermediate shadow contents never appear on `q`.
- Step: when `step && valid` and no commit occurs this edge, `addr = addr ± zero-extended stride`, modulo 2^`ADDR_W`.
  - `wrap` = carry out (add) or borrow out (subtract). It is registered, lasts one cycle, and is 0 on any edge without an effective step.
- Step with `valid==0` is ignored (`addr` unchanged, `wrap=0`).
- Stride 0 leaves `addr` unchanged and gives `wrap=0`.
- Simultaneous events:
  - Committing `ld` together with `step`: the commit wins and the step is dropped.
  - Non-committing `ld` together with `step`: both act; the step modifies `addr` while the shadow fills.
- `q` and `valid` are independent: `oe` does not affect `valid`. `valid` clears only on reset.

## Timing
- `q`, `valid`, `busy`, `wrap` are driven from registers only. `q` additionally passes through a combinational AND with `oe`, so `q` responds to `oe` in the same cycle.
- Load latency: the new address appears on `q` immediately after the edge that samples the final `ld` beat. For `ADDR_W=16`, `DATA_W=8`, that is 2 `ld` edges.
- Step latency: 1 edge. `wrap` is asserted for the cycle following the stepping edge.
- Back-to-back operation:
  - `ld` may be held high continuously; consecutive load sequences proceed with no bubble.
  - `step` may be held high; `addr` changes every edge.

## Structure
- `eau_defs.vh`: FSM state encodings (`EAU_IDLE`, `EAU_LOAD`) and the direction constants (`EAU_ADD`, `EAU_SUB`). Shared with future LSU address blocks.
- Sub-module `eau_step`: a purely combinational `ADDR_W+1`-bit add/subtract of the zero-extended stride, producing the next address and the carry/borrow bit.
- The top level contains the FSM, pointer, shadow, commit logic, and output gating.
- Elaboration-time check: stop with an error if `ADDR_W % DATA_W != 0`.

## Test plan
All scenarios use the defaults (`DATA_W=8`, `ADDR_W=16`, `STRIDE_W=4`).
1. **Reset.** Hold `rst=0` for 2 cycles, then release → `q=0x0000`, `valid=0`, `busy=0`, `wrap=0`.
2. **Load.** `oe=1`; `ld` with `d=0x64`, then `ld` with `d=0x40` → after the first edge `busy=1`, `q=0x0000`; after the second edge `q=0x4064`, `valid=1`, `busy=0`.
3. **Output gating.** Drop `oe` → `q=0x0000` in the same cycle with `valid=1`; raise `oe` → `q=0x4064`.
4. **Wrap on add.** Load `0xFFFE`, then `step` with `dir=0`, `stride=4` → `q=0x0002` and `wrap=1` for exactly 1 cycle.
5. **Reload with concurrent step.** With `addr=0x4064`:
   - `ld` `d=0x20` together with `step`, `dir=1`, `stride=1` → `q=0x4063`, `busy=1`.
   - Next: `ld` `d=0x10` with `step` still high → `q=0x1020`; the step is dropped.
6. **Reset mid-load.** After a single `ld` with `d=0x55`, pulse `rst=0` → all outputs 0. The next two `ld` beats `0xAA`, `0xBB` give `q=0xBBAA`, confirming the pointer restarted at beat 0.

Source files
------------

// File: rtl/eau_seq_pkg.sv
// rtl/eau_seq_pkg.sv - shared FSM encodings and step-direction constants for LSU address blocks
package eau_seq_pkg;

   typedef enum logic {
      EAU_IDLE = 1'b0,
      EAU_LOAD = 1'b1
   } eau_state_t;

   localparam logic EAU_ADD = 1'b0;
   localparam logic EAU_SUB = 1'b1;

   // Beat pointer width, never narrower than one bit so a single-beat build still elaborates.
   function automatic int eau_ptr_w(input int nbeat);
      return (nbeat > 1) ? $clog2(nbeat) : 1;
   endfunction

endpackage

// File: rtl/eau_step.sv
// rtl/eau_step.sv - combinational post-modify adder/subtractor with carry/borrow out
module eau_step
   import eau_seq_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int STRIDE_W = 4
) (
   input  logic [ADDR_W-1:0]   a,
   input  logic [STRIDE_W-1:0] stride,
   input  logic                dir,
   output logic [ADDR_W-1:0]   nxt,
   output logic                cout
);

   logic [ADDR_W:0] ext_a;
   logic [ADDR_W:0] ext_s;
   logic [ADDR_W:0] res;

   assign ext_a = {1'b0, a};
   assign ext_s = {{(ADDR_W + 1 - STRIDE_W){1'b0}}, stride};

   // One extra bit holds the carry on add; on subtract it goes high exactly when stride > a.
   assign res  = (dir == EAU_SUB) ? (ext_a - ext_s) : (ext_a + ext_s);
   assign nxt  = res[ADDR_W-1:0];
   assign cout = res[ADDR_W];

endmodule

// File: rtl/eau_seq.sv
// rtl/eau_seq.sv - effective-address unit: beat-wise shadow load, atomic commit, post-modify step
module eau_seq
   import eau_seq_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 16,
   parameter int STRIDE_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   d,
   input  logic                ld,
   input  logic                step,
   input  logic                dir,
   input  logic [STRIDE_W-1:0] stride,
   input  logic                oe,
   output logic [ADDR_W-1:0]   q,
   output logic                valid,
   output logic                busy,
   output logic                wrap
);

   localparam int NBEAT = ADDR_W / DATA_W;
   localparam int PTR_W = eau_ptr_w(NBEAT);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NBEAT - 1);

   if ((ADDR_W % DATA_W) != 0 || NBEAT < 1) begin : g_chk
      $error("eau_seq: ADDR_W must be a positive multiple of DATA_W");
   end

   eau_state_t        state, state_nx;
   logic [PTR_W-1:0]  ptr, ptr_nx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] shadow, shadow_nx;
   logic [ADDR_W-1:0] addr_step;
   logic              carry;
   logic              commit;
   logic              step_en;

   eau_step #(
      .ADDR_W   (ADDR_W),
      .STRIDE_W (STRIDE_W)
   ) u_step (
      .a      (addr),
      .stride (stride),
      .dir    (dir),
      .nxt    (addr_step),
      .cout   (carry)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= EAU_IDLE;
         ptr    <= '0;
         shadow <= '0;
         addr   <= '0;
         valid  <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         state  <= state_nx;
         ptr    <= ptr_nx;
         shadow <= shadow_nx;
         wrap   <= step_en & carry;
         if (commit) begin
            addr  <= shadow_nx;
            valid <= 1'b1;
         end else if (step_en) begin
            addr <= addr_step;
         end
      end
   end

   // The committed value is the shadow with the final beat already merged in.
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      shadow_nx = shadow;
      commit    = 1'b0;
      if (ld) begin
         shadow_nx[int'(ptr) * DATA_W +: DATA_W] = d;
      end
      case (state)
         EAU_IDLE: begin
            if (ld) begin
               if (NBEAT == 1) begin
                  commit = 1'b1;
               end else begin
                  ptr_nx   = PTR_W'(1);
                  state_nx = EAU_LOAD;
               end
            end
         end
         EAU_LOAD: begin
            if (ld) begin
               if (ptr == LAST) begin
                  commit   = 1'b1;
                  ptr_nx   = '0;
                  state_nx = EAU_IDLE;
               end else begin
                  ptr_nx = ptr + PTR_W'(1);
               end
            end
         end
         default: begin
            state_nx = EAU_IDLE;
            ptr_nx   = '0;
         end
      endcase
      step_en = step & valid & ~commit;
   end

   assign busy = (state == EAU_LOAD);
   assign q    = (oe && valid) ? addr : '0;

endmodule
